rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 7 +
 rtl/rf_wb_arbiter_if.sv | 36 +++
 rtl/rf_wb_arbiter_scoreboard.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 56 +++++
 tb/tb_rf_wb_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, defaults and grant encoding for the writeback arbiter slice.
package rf_wb_arbiter_pkg;
   localparam int REG_IDX_W = 4;
   localparam int NUM_REGS = 16;
   localparam int DATA_W = 32;
   typedef enum logic {GRANT_ALU, GRANT_LSU} grant_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requests, issue-stage marks, hazard queries and register-file write port.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W,
   parameter int NUM_REGS = rf_wb_arbiter_pkg::NUM_REGS
);
   import rf_wb_arbiter_pkg::*;
   logic alu_valid;
   logic alu_ready;
   logic [REG_IDX_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_wd;
   logic lsu_valid;
   logic lsu_ready;
   logic [REG_IDX_W-1:0] lsu_rd;
   logic [DATA_W-1:0] lsu_wd;
   logic mark_valid;
   logic mark_ready;
   logic [REG_IDX_W-1:0] mark_rd;
   logic [REG_IDX_W-1:0] q_rs1;
   logic [REG_IDX_W-1:0] q_rs2;
   logic [REG_IDX_W-1:0] q_rs3;
   logic hazard;
   logic [REG_IDX_W-1:0] RD;
   logic [DATA_W-1:0] WD;
   logic wr_enable;
   logic [NUM_REGS-1:0] busy;
   modport master (
      output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
             mark_valid, mark_rd, q_rs1, q_rs2, q_rs3,
      input  alu_ready, lsu_ready, mark_ready, hazard, RD, WD, wr_enable, busy
   );
   modport slave (
      input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
             mark_valid, mark_rd, q_rs1, q_rs2, q_rs3,
      output alu_ready, lsu_ready, mark_ready, hazard, RD, WD, wr_enable, busy
   );
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: pending-write vector with issue-stage marks, writeback clears and source hazard decode.
module rf_scoreboard #(
   parameter int NUM_REGS = rf_wb_arbiter_pkg::NUM_REGS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_mark_valid,
   output logic o_mark_ready,
   input  logic [rf_wb_arbiter_pkg::REG_IDX_W-1:0] i_mark_rd,
   input  logic i_clr_en,
   input  logic [rf_wb_arbiter_pkg::REG_IDX_W-1:0] i_clr_rd,
   input  logic [rf_wb_arbiter_pkg::REG_IDX_W-1:0] i_q_rs1,
   input  logic [rf_wb_arbiter_pkg::REG_IDX_W-1:0] i_q_rs2,
   input  logic [rf_wb_arbiter_pkg::REG_IDX_W-1:0] i_q_rs3,
   output logic o_hazard,
   output logic [NUM_REGS-1:0] o_busy
);
   import rf_wb_arbiter_pkg::*;
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;
   // Index 0 is never set, so it reads idle and never stalls a mark.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      o_mark_ready = ~r_busy[i_mark_rd];
      if (i_mark_valid && o_mark_ready && i_mark_rd != '0) w_set[i_mark_rd] = 1'b1;
      if (i_clr_en) w_clr[i_clr_rd] = 1'b1;
      o_hazard = r_busy[i_q_rs1] | r_busy[i_q_rs2] | r_busy[i_q_rs3];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_busy <= '0;
      else r_busy <= (r_busy & ~w_clr) | w_set;
   assign o_busy = r_busy;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/LSU writeback arbiter with one-cycle output staging
// and a register scoreboard for issue-stage hazard checks.
module rf_wb_arbiter #(
   parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W,
   parameter int NUM_REGS = rf_wb_arbiter_pkg::NUM_REGS
) (
   input logic clk,
   input logic rst_n,
   rf_wb_arbiter_if.slave bus
);
   import rf_wb_arbiter_pkg::*;
   grant_t r_last_grant;
   logic r_wen;
   logic [REG_IDX_W-1:0] r_rd;
   logic [DATA_W-1:0] r_wd;
   logic w_alu_fire;
   logic w_lsu_fire;
   // On conflict the side not granted last wins; last_grant only moves on a transfer.
   always_comb begin
      bus.alu_ready = bus.alu_valid & (~bus.lsu_valid | (r_last_grant == GRANT_LSU));
      bus.lsu_ready = bus.lsu_valid & (~bus.alu_valid | (r_last_grant == GRANT_ALU));
      w_alu_fire = bus.alu_valid & bus.alu_ready;
      w_lsu_fire = bus.lsu_valid & bus.lsu_ready;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_last_grant <= GRANT_LSU;
         r_wen <= 1'b0;
         r_rd <= '0;
         r_wd <= '0;
      end else begin
         r_wen <= w_alu_fire | w_lsu_fire;
         if (w_alu_fire | w_lsu_fire) begin
            r_last_grant <= w_alu_fire ? GRANT_ALU : GRANT_LSU;
            r_rd <= w_alu_fire ? bus.alu_rd : bus.lsu_rd;
            r_wd <= w_alu_fire ? bus.alu_wd : bus.lsu_wd;
         end
      end
   assign bus.RD = r_rd;
   assign bus.WD = r_wd;
   assign bus.wr_enable = r_wen;
   rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
      .clk(clk),
      .rst_n(rst_n),
      .i_mark_valid(bus.mark_valid),
      .o_mark_ready(bus.mark_ready),
      .i_mark_rd(bus.mark_rd),
      .i_clr_en(r_wen),
      .i_clr_rd(r_rd),
      .i_q_rs1(bus.q_rs1),
      .i_q_rs2(bus.q_rs2),
      .i_q_rs3(bus.q_rs3),
      .o_hazard(bus.hazard),
      .o_busy(bus.busy)
   );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vectors with hand-computed expectations for rf_wb_arbiter.
module tb_rf_wb_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_total = 0;
   int n_bad = 0;
   rf_wb_arbiter_if #(.DATA_W(32), .NUM_REGS(16)) bus ();
   rf_wb_arbiter #(.DATA_W(32), .NUM_REGS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_wd = 0;
      bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_wd = 0;
      bus.mark_valid = 0; bus.mark_rd = 0;
      bus.q_rs1 = 0; bus.q_rs2 = 0; bus.q_rs3 = 0;
      step(); step();
      chk("rst_wen", bus.wr_enable, 0);
      chk("rst_rd", bus.RD, 0);
      chk("rst_wd", bus.WD, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1;
      step();
      // single ALU write
      bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_wd = 32'hDEADBEEF;
      #1;
      chk("alu_only_ready", bus.alu_ready, 1);
      chk("alu_only_lsu_ready", bus.lsu_ready, 0);
      step();
      bus.alu_valid = 0;
      chk("alu_wen", bus.wr_enable, 1);
      chk("alu_rd", bus.RD, 5);
      chk("alu_wd", bus.WD, 32'hDEADBEEF);
      step();
      chk("idle_wen", bus.wr_enable, 0);
      // lone LSU write hands last_grant back to LSU
      bus.lsu_valid = 1; bus.lsu_rd = 9; bus.lsu_wd = 32'h99;
      #1;
      chk("lsu_only_ready", bus.lsu_ready, 1);
      step();
      chk("lsu_rd", bus.RD, 9);
      chk("lsu_wen", bus.wr_enable, 1);
      // conflict: alternate ALU, LSU, ALU, LSU
      bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_wd = 32'h11;
      bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_wd = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr_alu_ready%0d", i), bus.alu_ready, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("rr_lsu_ready%0d", i), bus.lsu_ready, (i % 2 == 0) ? 0 : 1);
         step();
         chk($sformatf("rr_rd%0d", i), bus.RD, (i % 2 == 0) ? 1 : 2);
         chk($sformatf("rr_wd%0d", i), bus.WD, (i % 2 == 0) ? 32'h11 : 32'h22);
         chk($sformatf("rr_wen%0d", i), bus.wr_enable, 1);
      end
      bus.alu_valid = 0; bus.lsu_valid = 0;
      step();
      chk("rr_idle_wen", bus.wr_enable, 0);
      // mark 7 then hazard until LSU writeback clears it
      bus.mark_valid = 1; bus.mark_rd = 7;
      #1;
      chk("mark7_ready", bus.mark_ready, 1);
      step();
      bus.mark_valid = 0; bus.q_rs2 = 7;
      #1;
      chk("mark7_busy", bus.busy, 16'h0080);
      chk("mark7_hazard", bus.hazard, 1);
      bus.mark_valid = 1; bus.mark_rd = 7;
      bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_wd = 32'h77;
      #1;
      chk("waw_stall", bus.mark_ready, 0);
      chk("wb7_lsu_ready", bus.lsu_ready, 1);
      step();
      bus.lsu_valid = 0;
      chk("wb7_wen", bus.wr_enable, 1);
      chk("wb7_rd", bus.RD, 7);
      chk("wb7_hazard_still", bus.hazard, 1);
      chk("waw_stall_still", bus.mark_ready, 0);
      step();
      chk("wb7_hazard_clear", bus.hazard, 0);
      chk("waw_released", bus.mark_ready, 1);
      chk("wb7_busy", bus.busy, 0);
      bus.mark_rd = 0;
      #1;
      chk("mark0_ready", bus.mark_ready, 1);
      step();
      bus.mark_valid = 0;
      chk("mark0_busy", bus.busy, 0);
      // same-cycle set and clear of index 3
      bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_wd = 32'h33;
      step();
      bus.alu_valid = 0;
      bus.mark_valid = 1; bus.mark_rd = 3;
      #1;
      chk("sc_wen", bus.wr_enable, 1);
      chk("sc_rd", bus.RD, 3);
      chk("sc_mark_ready", bus.mark_ready, 1);
      step();
      bus.mark_valid = 0;
      chk("sc_busy", bus.busy, 16'h0008);
      bus.q_rs2 = 0; bus.q_rs1 = 3;
      #1;
      chk("hz_rs1", bus.hazard, 1);
      bus.q_rs1 = 0; bus.q_rs3 = 3;
      #1;
      chk("hz_rs3", bus.hazard, 1);
      bus.q_rs3 = 4;
      #1;
      chk("hz_none", bus.hazard, 0);
      // writes to an idle index and to index 0
      bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_wd = 32'h99;
      step();
      chk("idle_wb_rd", bus.RD, 9);
      bus.alu_rd = 0; bus.alu_wd = 32'hABCD;
      step();
      bus.alu_valid = 0;
      chk("r0_rd", bus.RD, 0);
      chk("r0_wd", bus.WD, 32'hABCD);
      chk("r0_wen", bus.wr_enable, 1);
      step();
      chk("idle_wb_busy", bus.busy, 16'h0008);
      // reset right after an accepted ALU write
      bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_wd = 32'h44;
      step();
      chk("pre_rst_wen", bus.wr_enable, 1);
      rst_n = 0;
      #1;
      chk("async_rst_wen", bus.wr_enable, 0);
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_rd", bus.RD, 0);
      chk("async_rst_wd", bus.WD, 0);
      chk("rst_alu_ready", bus.alu_ready, 1);
      step();
      chk("rst_edge_wen", bus.wr_enable, 0);
      rst_n = 1;
      bus.alu_valid = 0;
      step();
      chk("post_rst_wen", bus.wr_enable, 0);
      bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_wd = 32'h11;
      bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_wd = 32'h22;
      #1;
      chk("post_rst_alu_ready", bus.alu_ready, 1);
      chk("post_rst_lsu_ready", bus.lsu_ready, 0);
      step();
      bus.alu_valid = 0; bus.lsu_valid = 0;
      chk("post_rst_rd", bus.RD, 1);
      step();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
